// File: rtl/cluster_unpacker_pkg.sv
// cluster_unpacker_pkg
//   Shared constants and helpers for the cluster unpacker.
//   - Supported pad-count / address-width pairs (192/8 and 384/9).
//   - Cluster count width (the count field holds size-1).
//   - Encoder "no cluster" key (address all ones).
//   - pad_in_cluster(): one bit of the cluster pad mask.
package cluster_unpacker_pkg;

  localparam int unsigned KEYS_192    = 192;
  localparam int unsigned KEYBITS_192 = 8;
  localparam int unsigned KEYS_384    = 384;
  localparam int unsigned KEYBITS_384 = 9;
  localparam int unsigned CNTB        = 3;
  localparam int unsigned CLST_MAX    = 16;

  // The encoder reports "no cluster" with an all-ones address, which is
  // always outside the pad range for both supported sizes.
  localparam logic [KEYBITS_192-1:0] NONE_KEY_192 = '1;
  localparam logic [KEYBITS_384-1:0] NONE_KEY_384 = '1;

  // True when pad lies within adr..adr+cnt. Evaluated only for pads that
  // exist, so pads past the top of the array are clipped implicitly.
  function automatic logic pad_in_cluster(input int unsigned pad,
                                          input int unsigned adr,
                                          input int unsigned cnt);
    return (pad >= adr) && (pad <= adr + cnt);
  endfunction

endpackage

// File: rtl/cluster_mask_gen.sv
// cluster_mask_gen
//   Combinational expansion of one cluster into a pad mask.
//   Ports:
//     adr      in   MXKEYBITS  cluster start pad
//     cnt      in   MXCNTB     cluster size minus one
//     mask     out  MXKEYS     pads adr..adr+cnt, clipped at MXKEYS-1
//     adr_err  out  1          adr is outside the pad array
module cluster_mask_gen
  import cluster_unpacker_pkg::*;
#(
  parameter int unsigned MXKEYS    = KEYS_192,
  parameter int unsigned MXKEYBITS = KEYBITS_192,
  parameter int unsigned MXCNTB    = CNTB
) (
  input  logic [MXKEYBITS-1:0] adr,
  input  logic [MXCNTB-1:0]    cnt,
  output logic [MXKEYS-1:0]    mask,
  output logic                 adr_err
);

  assign adr_err = 32'(adr) >= MXKEYS;

  // An out-of-range address can never cover an existing pad, so the mask
  // is already zero in that case without extra gating.
  for (genvar gi = 0; gi < MXKEYS; gi++) begin : g_pad
    assign mask[gi] = pad_in_cluster(gi, 32'(adr), 32'(cnt));
  end

endmodule

// File: rtl/cluster_unpacker.sv
// cluster_unpacker
//   Rebuilds the per-pad valid bitmap from a stream of clusters, one cluster
//   per cycle, OR-accumulated over a frame and published at frame end.
//   Ports:
//     clock          in   1          system clock
//     reset_n        in   1          asynchronous active-low reset
//     clst_vpf_i     in   1          cluster valid strobe
//     clst_adr_i     in   MXKEYBITS  cluster start pad
//     clst_cnt_i     in   MXCNTB     cluster size minus one
//     frame_end_i    in   1          last cycle of the current frame
//     pass_i         in   3          frame tag, sampled with frame_end_i
//     vpfs_o         out  MXKEYS     bitmap of the last completed frame
//     frame_valid_o  out  1          one-cycle pulse when outputs update
//     pass_o         out  3          tag of the published frame
//     nclst_o        out  NCW        clusters accepted in published frame
//     overflow_o     out  1          published frame exceeded MXCLST
//     adr_err_o      out  1          published frame had an out-of-range adr
module cluster_unpacker
  import cluster_unpacker_pkg::*;
#(
  parameter int unsigned MXKEYS    = KEYS_192,
  parameter int unsigned MXKEYBITS = KEYBITS_192,
  parameter int unsigned MXCNTB    = CNTB,
  parameter int unsigned MXCLST    = CLST_MAX,
  localparam int unsigned NCW      = $clog2(MXCLST + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clst_vpf_i,
  input  logic [MXKEYBITS-1:0] clst_adr_i,
  input  logic [MXCNTB-1:0]    clst_cnt_i,
  input  logic                 frame_end_i,
  input  logic [2:0]           pass_i,
  output logic [MXKEYS-1:0]    vpfs_o,
  output logic                 frame_valid_o,
  output logic [2:0]           pass_o,
  output logic [NCW-1:0]       nclst_o,
  output logic                 overflow_o,
  output logic                 adr_err_o
);

  logic [MXKEYS-1:0] mask;
  logic              adr_err;

  logic [MXKEYS-1:0] acc_reg, acc_next;
  logic [NCW-1:0]    cnt_reg, cnt_next;
  logic              ovf_reg, ovf_next;
  logic              aerr_reg, aerr_next;
  logic              accept;

  cluster_mask_gen #(
    .MXKEYS   (MXKEYS),
    .MXKEYBITS(MXKEYBITS),
    .MXCNTB   (MXCNTB)
  ) u_mask (
    .adr    (clst_adr_i),
    .cnt    (clst_cnt_i),
    .mask   (mask),
    .adr_err(adr_err)
  );

  // Address error outranks overflow: a bad address never reaches the
  // capacity test, so it cannot set the overflow flag.
  always_comb begin
    accept    = clst_vpf_i && !adr_err && (cnt_reg < NCW'(MXCLST));
    acc_next  = acc_reg | (accept ? mask : '0);
    cnt_next  = cnt_reg + NCW'(accept);
    ovf_next  = ovf_reg | (clst_vpf_i && !adr_err && !accept);
    aerr_next = aerr_reg | (clst_vpf_i && adr_err);
  end

  // At frame end the *_next values (which include this cycle's cluster) are
  // published and the accumulator restarts empty for the next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      aerr_reg      <= 1'b0;
      vpfs_o        <= '0;
      frame_valid_o <= 1'b0;
      pass_o        <= '0;
      nclst_o       <= '0;
      overflow_o    <= 1'b0;
      adr_err_o     <= 1'b0;
    end else begin
      frame_valid_o <= frame_end_i;
      if (frame_end_i) begin
        vpfs_o     <= acc_next;
        pass_o     <= pass_i;
        nclst_o    <= cnt_next;
        overflow_o <= ovf_next;
        adr_err_o  <= aerr_next;
        acc_reg    <= '0;
        cnt_reg    <= '0;
        ovf_reg    <= 1'b0;
        aerr_reg   <= 1'b0;
      end else begin
        acc_reg    <= acc_next;
        cnt_reg    <= cnt_next;
        ovf_reg    <= ovf_next;
        aerr_reg   <= aerr_next;
      end
    end
  end

endmodule

// File: doc/cluster_unpacker.md
Name: cluster_unpacker

Overview:
- Inverse of the cluster priority encoder: rebuilds the per-pad valid bitmap (vpfs) from a stream of clusters. Each cluster is a start address plus a 3-bit count (size-1).
- Clusters arrive one per cycle over one bunch-crossing frame and are OR-accumulated into a bitmap.
- At frame end the bitmap is published and the accumulator is cleared.
- Used in the emulator/loopback path to compare reconstructed hits against the original S-bits, and as a verification reference model.

Parameters:
- MXKEYS, 192, number of pads (192 or 384 supported).
- MXKEYBITS, 8, address width (9 when MXKEYS=384).
- MXCNTB, 3, cluster count width; cluster spans cnt+1 pads.
- MXCLST, 16, maximum clusters accepted per frame; later clusters are dropped.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clst_vpf_i  in  1  cluster valid strobe
- clst_adr_i  in  MXKEYBITS  cluster start pad address
- clst_cnt_i  in  MXCNTB  cluster size minus one
- frame_end_i  in  1  last cycle of the current frame
- pass_i  in  3  frame tag, sampled at frame_end_i
- vpfs_o  out  MXKEYS  reconstructed pad bitmap of the last completed frame
- frame_valid_o  out  1  one-cycle pulse: vpfs_o/pass_o updated
- pass_o  out  3  tag of the published frame
- nclst_o  out  $clog2(MXCLST+1)  clusters accepted in the published frame
- overflow_o  out  1  published frame had more than MXCLST clusters
- adr_err_o  out  1  published frame had a cluster with clst_adr_i >= MXKEYS

Behaviour:
- Reset (async assert, sync-deasserted use assumed upstream):
  - vpfs_o=0, frame_valid_o=0, pass_o=0, nclst_o=0, overflow_o=0, adr_err_o=0.
  - Accumulator, cluster counter and sticky flags all cleared.
- Accept rule: a cluster is accepted when clst_vpf_i=1, clst_adr_i<MXKEYS, and accepted count<MXCLST.
  - Accepted cluster: OR pads adr..adr+cnt into the accumulator; increment the count.
- Clipping: pads with index >= MXKEYS are discarded. No wrap to pad 0 and no error, because clusters at the upper edge are legal.
- Address error: clst_vpf_i=1 with adr>=MXKEYS (e.g. encoder "none" key all-ones) is ignored for the bitmap and the count, and sets sticky adr_err.
- Overflow: clst_vpf_i=1 with a valid address when count already equals MXCLST → cluster dropped, sticky overflow set. Address error takes precedence: such a cluster does not set overflow.
- clst_vpf_i=0: address and count inputs are ignored.
- frame_end_i=1 in cycle N:
  - Any cluster presented in cycle N belongs to the closing frame and is included.
  - At edge N+1: vpfs_o, nclst_o, overflow_o, adr_err_o take the frame's final values; pass_o takes pass_i from cycle N; frame_valid_o=1 for exactly one cycle.
  - Accumulator, count and sticky flags clear at the same edge, so the cycle N+1 cluster starts a fresh frame.
- Latency: one clock from frame_end_i to frame_valid_o.
- Outputs hold between frames.
- Back-to-back frame_end_i is legal. An empty frame publishes vpfs_o=0, nclst_o=0.
- Overlapping or duplicate clusters OR together; each one still counts.
- Reset mid-frame discards the partial frame; no frame_valid_o is produced for it.
- No backpressure: the block accepts every cycle.

Decomposition:
- Shared package:
  - MXKEYS/MXKEYBITS pairs (192/8, 384/9) and MXCNTB=3.
  - Encoder "no cluster" key constant (all ones).
  - Function computing the cluster pad mask.
- One combinational sub-module: cluster_mask_gen. Inputs adr and cnt; output is an MXKEYS-wide mask with clipping and an address-range error flag.
- The top holds the accumulator, counters, flags and output registers.

Test Plan:
- MXKEYS=192. Cluster adr=10 cnt=2, then frame_end → next cycle vpfs_o bits 10,11,12 set only; nclst_o=1; frame_valid_o pulses once; pass_o equals pass_i sampled at frame_end.
- Edge clip: adr=189 cnt=7 → bits 189..191 set; adr_err_o=0. Invalid address: adr=255 with valid → no bits set; adr_err_o=1; nclst_o=0.
- Overflow: 17 valid clusters at adr=0,8,...,128 cnt=0 → first 16 pads present, pad 128 absent; nclst_o=16; overflow_o=1.
- Cluster in the same cycle as frame_end: adr=50 cnt=0 → included in the published frame. Cluster adr=60 in the next cycle → appears only in the following frame.
- Reset asserted mid-frame after clusters, then released and frame_end → vpfs_o=0, nclst_o=0. No frame_valid_o during reset. All outputs zero immediately on reset assertion.
- Round trip: random bitmap → priority encoder (run repeatedly with the found cluster masked out) → cluster_unpacker → vpfs_o equals the input bitmap. Check at MXKEYS=192 and 384.
